// File: rtl/cpu_pkg.sv
// Shared CPU constants and the return-stack operation encoding.
package cpu_pkg;

    localparam int XLEN      = 19;
    localparam int RAS_DEPTH = 8;

    // Bit order matches the {push, pop} concatenation used to decode it.
    typedef enum logic [1:0] {
        RAS_NONE    = 2'b00,
        RAS_POP     = 2'b01,
        RAS_PUSH    = 2'b10,
        RAS_REPLACE = 2'b11
    } ras_op_e;

endpackage

// File: rtl/ras_mem.sv
// Return-stack storage: register array, one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module ras_mem #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  wAddr,
    input  logic [DATA_W-1:0] wData,
    input  logic [PTR_W-1:0]  rAddr,
    output logic [DATA_W-1:0] rData
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wAddr] <= wData;
        end
    end

    assign rData = mem[rAddr];

endmodule

// File: rtl/return_addr_stack.sv
// Call/return address stack for the decode stage: circular storage with
// push, pop, replace (push+pop), flush, occupancy and sticky error flags.
module return_addr_stack
    import cpu_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int DEPTH    = RAS_DEPTH,
    parameter int OVF_WRAP = 0,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              clear_err,
    output logic [DATA_W-1:0] top_data,
    output logic              top_valid,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    ras_op_e           op;
    logic [PTR_W-1:0]  tos;
    logic [PTR_W-1:0]  nextTos;
    logic [PTR_W-1:0]  tosInc;
    logic [PTR_W-1:0]  wAddr;
    logic [PTR_W:0]    cnt;
    logic [PTR_W:0]    nextCnt;
    logic              we;
    logic              isFull;
    logic              isEmpty;
    logic              setOvf;
    logic              setUnf;
    logic              ovfErr;
    logic              unfErr;
    logic [DATA_W-1:0] rdData;

    assign op      = ras_op_e'({push, pop});
    assign isFull  = (cnt == FULL_CNT);
    assign isEmpty = (cnt == '0);
    assign tosInc  = tos + PTR_ONE;

    ras_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) uMem (
        .clk   (clk),
        .we    (we),
        .wAddr (wAddr),
        .wData (push_data),
        .rAddr (tos),
        .rData (rdData)
    );

    // Next pointer/count, write strobe and error-set events for this cycle.
    always_comb begin
        nextTos = tos;
        nextCnt = cnt;
        we      = 1'b0;
        wAddr   = tos;
        setOvf  = 1'b0;
        setUnf  = 1'b0;
        if (flush) begin
            nextTos = '0;
            nextCnt = '0;
        end else begin
            unique case (op)
                RAS_PUSH: begin
                    if (isEmpty) begin
                        // Empty stack: tos already names the free slot.
                        we      = 1'b1;
                        wAddr   = tos;
                        nextCnt = CNT_ONE;
                    end else if (!isFull) begin
                        we      = 1'b1;
                        wAddr   = tosInc;
                        nextTos = tosInc;
                        nextCnt = cnt + CNT_ONE;
                    end else begin
                        setOvf = 1'b1;
                        if (OVF_WRAP != 0) begin
                            // When full, tos+1 is the oldest entry: overwrite it.
                            we      = 1'b1;
                            wAddr   = tosInc;
                            nextTos = tosInc;
                        end
                    end
                end
                RAS_POP: begin
                    if (isEmpty) begin
                        setUnf = 1'b1;
                    end else begin
                        nextTos = tos - PTR_ONE;
                        nextCnt = cnt - CNT_ONE;
                    end
                end
                RAS_REPLACE: begin
                    we    = 1'b1;
                    wAddr = tos;
                    if (isEmpty) begin
                        setUnf  = 1'b1;
                        nextCnt = CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos <= '0;
            cnt <= '0;
        end else begin
            tos <= nextTos;
            cnt <= nextCnt;
        end
    end

    // Sticky error flags; a set event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovfErr <= 1'b0;
            unfErr <= 1'b0;
        end else begin
            ovfErr <= setOvf | (ovfErr & ~clear_err);
            unfErr <= setUnf | (unfErr & ~clear_err);
        end
    end

    assign top_data      = isEmpty ? '0 : rdData;
    assign top_valid     = ~isEmpty;
    assign count         = cnt;
    assign full          = isFull;
    assign empty         = isEmpty;
    assign overflow_err  = ovfErr;
    assign underflow_err = unfErr;

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Parametrised hardware call/return stack for the decode stage of the 19-bit pipelined CPU.
- Replaces the fixed-depth stack_pointer instance.
- Decode pushes pcplus4D on a call and pops on a return; the top-of-stack value feeds the return-target mux.
- Adds the following over the previous stack: configurable depth and width, simultaneous push+pop, selectable overflow policy, a flush port, occupancy count and sticky error flags.

Parameters:
- DATA_W, 19, entry width (return-address width).
- DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- OVF_WRAP, 0, overflow policy: 0 = drop the push when full; 1 = overwrite the oldest entry (circular).
- PTR_W, $clog2(DEPTH), derived; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of stack contents (pipeline redirect).
- push  in  1  push request, sampled at posedge.
- pop  in  1  pop request, sampled at posedge.
- push_data  in  DATA_W  value to push (pcplus4D).
- clear_err  in  1  synchronous clear of the sticky error flags.
- top_data  out  DATA_W  current top entry, combinational from state; 0 when empty.
- top_valid  out  1  high when the stack is not empty.
- count  out  PTR_W+1  occupancy, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow_err  out  1  sticky; set by a push rejected or overwritten while full.
- underflow_err  out  1  sticky; set by a pop while empty.

Behaviour:
- Reset (rst=0, asynchronous): tos pointer=0, count=0, overflow_err=0, underflow_err=0.
  - Outputs during reset: top_data=0, top_valid=0, empty=1, full=0.
  - Storage array is not reset; top_data is forced to 0 whenever empty.
- Storage: circular array mem[DEPTH]. tos indexes the top entry. The push slot is tos+1 mod DEPTH, except when empty, where the push slot is tos itself.
- All state updates happen at posedge clk. Results are visible on top_data/count in the following cycle (latency 1). Outputs are a combinational view of registered state.
- Per-cycle priority: flush > push/pop combination.
  - flush=1: count:=0, tos:=0. push and pop are ignored that cycle. Error flags are untouched.
  - push only, not full: write the slot, advance tos (unless previously empty), count+1.
  - push only, full, OVF_WRAP=0: no state change; overflow_err:=1.
  - push only, full, OVF_WRAP=1: tos:=tos+1 mod DEPTH and mem[tos] overwritten (oldest entry lost); count stays DEPTH; overflow_err:=1.
  - pop only, not empty: tos:=tos-1 mod DEPTH, count-1. Popped value is top_data in the cycle of the pop.
  - pop only, empty: no change; underflow_err:=1.
  - push+pop, not empty: replace — mem[tos]:=push_data; tos and count unchanged.
  - push+pop, empty: treated as push only (count:=1); underflow_err:=1.
- Error flags:
  - clear_err=1 clears both flags.
  - A set event in the same cycle as clear_err wins (flag ends at 1).
- Pointer arithmetic is modulo DEPTH via PTR_W-bit wrap. count never exceeds DEPTH and never goes below 0.
- full and empty are derived from count and are never simultaneously 1.

Decomposition:
- Shared cpu_pkg constants: XLEN=19 (default DATA_W), RAS_DEPTH=8.
- Shared cpu_pkg typedef: ras_op_e {RAS_NONE, RAS_PUSH, RAS_POP, RAS_REPLACE}, decoded internally from {push,pop}.
- One natural sub-module: ras_mem, a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port. Pointer/count control stays in the top module.

Test Plan:
- Reset then push 0x00010, 0x00020, 0x00030 -> count=3, top_data=0x00030; three pops return 0x00030, 0x00020, 0x00010; then empty=1, top_data=0.
- Pop on empty -> count stays 0, underflow_err=1; clear_err pulse -> underflow_err=0.
- OVF_WRAP=0, DEPTH=8: push 1..9 -> full=1, count=8, overflow_err=1, top_data=8; popping all yields 8..1.
- OVF_WRAP=1, DEPTH=8: push 1..10 -> count=8, top_data=10, overflow_err=1; popping all yields 10..3.
- Push 0x00100, 0x00200, then push+pop with 0x00300 -> count=2, top_data=0x00300; pop -> top_data=0x00100. Push+pop on empty with 0x00044 -> count=1, top_data=0x00044, underflow_err=1.
- Two entries loaded, flush together with push -> count=0, empty=1, error flags unchanged. Assert rst mid-push -> all outputs at reset values immediately, without waiting for a clock edge.
